seven_segment_decoder: RTL and testbench
========================================

Name: seven_segment_decoder

Overview:
- Registered hex-to-seven-segment decoder for one display digit.
- Takes a 4-bit nibble on four scalar inputs (w = MSB, z = LSB) and drives a 7-bit segment pattern for digits 0-9 and A-F.
- Sits between a digit source (counter or mux) and the display pins.
- Output is registered, so the pins are glitch-free and the block is one pipeline stage.

Parameters:
- none

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- w  input  1  nibble bit 3 (MSB)
- x  input  1  nibble bit 2
- y  input  1  nibble bit 1
- z  input  1  nibble bit 0 (LSB)
- seg  output  7  segment drive, seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g; active-high by default

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: while rst=1 at a rising clk edge, seg <= 7'h00 (all segments off). Reset overrides any input value. Asserting rst mid-stream blanks seg on the next edge.
- Nibble: n = {w,x,y,z}.
- Latency: exactly 1 cycle. seg after edge k equals decode(n sampled at edge k). There is no handshake; a new nibble is accepted every cycle.
- Decode table, active-high, hex:
  - 0 -> 7E, 1 -> 30, 2 -> 6D, 3 -> 79
  - 4 -> 33, 5 -> 5B, 6 -> 5F, 7 -> 70
  - 8 -> 7F, 9 -> 7B, A -> 77, b -> 1F
  - C -> 4E, d -> 3D, E -> 4F, F -> 47
- Letters b and d are lower-case shapes; all others are upper-case or numeric.
- All 16 codes are defined; there is no invalid input.
- X/Z on any input bit: seg <= 7'h00 (blank). This is a simulation-only requirement.
- No other state. Holding an input constant holds seg constant.

Optional Feature:
- Macro: SEVEN_SEG_ACTIVE_LOW_EN.
- Defined: seg is the bitwise inverse of the table, for common-anode displays (e.g. 0 -> 01, 8 -> 00). Reset and blank values become 7'h7F, i.e. all segments off.
- Undefined: active-high, exactly as above.
- Latency and reset timing are identical in both builds.

Decomposition:
- Package seven_seg_pkg holds:
  - typedef seg_t (logic [6:0])
  - the 16 segment constants SEG_0..SEG_F
  - SEG_BLANK
- One combinational sub-module, hex_to_seg (nibble in, seg_t out, pure case table), instantiated by seven_segment_decoder.
- seven_segment_decoder adds the output register, reset and optional polarity inversion.

Test Plan:
- Reset: rst=1 for 2 cycles with n=8 -> seg=00 throughout; release rst -> seg=7F one cycle later.
- Exhaustive sweep: n=0..F, one per cycle -> seg follows the table with 1-cycle lag (0->7E, 1->30, ..., 9->7B, A->77, F->47).
- Mid-stream reset: sweep running, rst=1 for one cycle at n=5 -> seg=00 that cycle; next value decodes n normally (e.g. n=6 -> 5F).
- Hold stability: n=4 for 10 cycles -> seg stays 33, no toggling.
- Back-to-back changes: n alternates 1,8,1,8 -> seg 30,7F,30,7F every cycle.
- With SEVEN_SEG_ACTIVE_LOW_EN: reset -> 7F; n=0 -> 01; n=8 -> 00; n=F -> 38.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared segment type and active-high glyph constants for the hex display path.
// Bit order: seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_A     = 7'h77;
  // b and d use lower-case shapes so they stay distinct from 8 and 0
  localparam seg_t SEG_B     = 7'h1F;
  localparam seg_t SEG_C     = 7'h4E;
  localparam seg_t SEG_D     = 7'h3D;
  localparam seg_t SEG_E     = 7'h4F;
  localparam seg_t SEG_F     = 7'h47;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_decoder_hex_to_seg.sv
// Pure combinational nibble-to-glyph lookup, active-high.
// Any unknown nibble bit falls through to the blank pattern.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Registered hex-to-seven-segment decoder, one pipeline stage, synchronous reset.
// Define SEVEN_SEG_ACTIVE_LOW_EN for common-anode (inverted) segment drive.
module seven_segment_decoder
  import seven_seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       w,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic [6:0] seg
);

  seg_t dec_s;
  seg_t seg_d;
  seg_t seg_q;

  hex_to_seg u_hex_to_seg (
    .nibble_i ({w, x, y, z}),
    .seg_o    (dec_s)
  );

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
  localparam seg_t SEG_OFF = ~SEG_BLANK;
  assign seg_d = ~dec_s;
`else
  localparam seg_t SEG_OFF = SEG_BLANK;
  assign seg_d = dec_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: reset, full sweep, mid-stream reset,
// hold stability and back-to-back changes, in either polarity build.
module tb_seven_segment_decoder;

  logic       clk;
  logic       rst;
  logic       w, x, y, z;
  logic [6:0] seg;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [6:0] table_q [16];

  seven_segment_decoder dut (
    .clk (clk),
    .rst (rst),
    .w   (w),
    .x   (x),
    .y   (y),
    .z   (z),
    .seg (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pin value for an active-high pattern in the current build
  function automatic logic [6:0] pol(input logic [6:0] v);
`ifdef SEVEN_SEG_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic step(input logic r, input logic [3:0] n, input logic [6:0] exp_hi,
                      input string tag);
    rst = r;
    {w, x, y, z} = n;
    @(posedge clk);
    #1;
    n_cmp++;
    assert (seg === pol(exp_hi)) else begin
      n_bad++;
      $error("FAIL %s n=%h rst=%0b got %h expected %h", tag, n, r, seg, pol(exp_hi));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    table_q = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    rst = 1'b1;
    {w, x, y, z} = 4'h8;

    // Reset held two cycles with n=8, then release
    step(1'b1, 4'h8, 7'h00, "reset0");
    step(1'b1, 4'h8, 7'h00, "reset1");
    step(1'b0, 4'h8, 7'h7F, "release");

    // Full sweep, one nibble per cycle
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), table_q[i], "sweep");
    end

    // Mid-stream reset at n=5, then normal decode resumes
    step(1'b0, 4'h3, 7'h79, "pre_rst");
    step(1'b0, 4'h4, 7'h33, "pre_rst");
    step(1'b1, 4'h5, 7'h00, "mid_rst");
    step(1'b0, 4'h6, 7'h5F, "post_rst");
    step(1'b0, 4'h7, 7'h70, "post_rst");

    // Hold n=4 for ten cycles
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b0, 4'h4, 7'h33, "hold");
    end

    // Back-to-back alternation
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 4'h1, 7'h30, "alt1");
      step(1'b0, 4'h8, 7'h7F, "alt8");
    end

    // Letters with lower-case shapes and the polarity corner cases
    step(1'b0, 4'hB, 7'h1F, "lower_b");
    step(1'b0, 4'hD, 7'h3D, "lower_d");
    step(1'b0, 4'h0, 7'h7E, "zero");
    step(1'b0, 4'hF, 7'h47, "hexF");
    step(1'b1, 4'hF, 7'h00, "final_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
